hub75_scan_ctrl: RTL and testbench

Scan controller for the single-colour LED matrix board on the JA header. It sequences the R1/A/clk/lat board lines plus an active-low output enable (oe_n). For each row it reads pixels from an external frame memory and shifts them out. It then blanks the panel, updates the row address, latches, and holds the row lit for a programmed on-time, while the next row shifts in. It sits between the frame memory and the top-level pin wrapper.

---
 rtl/hub75_scan_ctrl_pkg.sv | 26 ++
 rtl/hub75_scan_ctrl_if.sv | 31 +++
 rtl/hub75_scan_ctrl_shifter.sv | 72 +++++++
 rtl/hub75_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared definitions for the HUB75 single-colour scan controller.
//   state_t   : scan FSM states
//   col_bits(): column-index width for a given COLS
//   DEF_*     : default timing constants used as parameter defaults
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLANK,
    LATCH
  } state_t;

  localparam int DEF_COLS      = 32;
  localparam int DEF_ROW_BITS  = 4;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_BLANK_CYC = 2;
  localparam int DEF_LAT_CYC   = 1;
  localparam int DEF_ON_CYC    = 256;

  function automatic int col_bits(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Bundle of the frame-memory read port and the LED board lines.
//   pix_addr/pix_rd : frame memory read request {row, col}, 1-cycle strobe
//   pix_data        : read data, one cycle after pix_rd
//   R1/A/clk/lat    : serial data, row address, shift clock, latch
//   oe_n            : output enable, active low
//   frame_done      : 1-cycle pulse after the last row latches
// master = scan controller, slave = memory/board side.
interface hub75_scan_ctrl_if #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 5
);
  logic [ROW_BITS+COL_BITS-1:0] pix_addr;
  logic                         pix_rd;
  logic                         pix_data;
  logic                         R1;
  logic [ROW_BITS-1:0]          A;
  logic                         clk;
  logic                         lat;
  logic                         oe_n;
  logic                         frame_done;

  modport master (
    output pix_addr, pix_rd, R1, A, clk, lat, oe_n, frame_done,
    input  pix_data
  );

  modport slave (
    input  pix_addr, pix_rd, R1, A, clk, lat, oe_n, frame_done,
    output pix_data
  );
endinterface

// File: rtl/hub75_scan_ctrl_shifter.sv
// Bit shifter for one panel row.
//   clk, rst  : system clock, synchronous active-high reset
//   start     : pulse; the following cycle is bit 0, phase 0
//   row_sh    : row being shifted (upper address bits)
//   pix_data  : frame memory data, valid the cycle after pix_rd
//   pix_addr  : {row_sh, col}
//   pix_rd    : read strobe in phase 0 of every bit
//   r1        : serial data, loaded from pix_data in phase 1
//   sclk      : shift clock, high in the second half of each bit
//   done      : high in the final cycle of the last bit
module hub75_bit_shifter
  import hub75_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int COL_BITS = col_bits(COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ROW_BITS-1:0]          row_sh,
  input  logic                         pix_data,
  output logic [ROW_BITS+COL_BITS-1:0] pix_addr,
  output logic                         pix_rd,
  output logic                         r1,
  output logic                         sclk,
  output logic                         done
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_HI   = DIV_W'(CLK_DIV);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

  logic                busy;
  logic [DIV_W-1:0]    div;
  logic [COL_BITS-1:0] col;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      div  <= '0;
      col  <= '0;
      r1   <= 1'b0;
    end else if (!busy) begin
      busy <= start;
      div  <= '0;
      col  <= '0;
    end else begin
      if (div == DIV_W'(1))
        r1 <= pix_data;
      if (div == DIV_LAST) begin
        div <= '0;
        if (col == COL_LAST) begin
          busy <= 1'b0;
          col  <= '0;
        end else begin
          col <= col + COL_BITS'(1);
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign pix_addr = {row_sh, col};
  assign pix_rd   = busy && (div == '0);
  assign sclk     = busy && (div >= DIV_HI);
  assign done     = busy && (div == DIV_LAST) && (col == COL_LAST);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 single-colour scan controller.
//   clkin, rstin : system clock, synchronous active-high reset
//   en           : scan enable, sampled in IDLE and at latch exit
//   bus          : memory read port and board lines (master side)
// Each row is shifted while the previous row is lit; the panel is then
// blanked, the row address updated, the row latched and lit again.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROW_BITS  = DEF_ROW_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int LAT_CYC   = DEF_LAT_CYC,
  parameter int ON_CYC    = DEF_ON_CYC
) (
  input  logic              clkin,
  input  logic              rstin,
  input  logic              en,
  hub75_scan_ctrl_if.master bus
);

  localparam int COL_BITS = col_bits(COLS);
  localparam int ON_W     = $clog2(ON_CYC + 1);
  localparam int CNT_MAX  = (BLANK_CYC > LAT_CYC) ? BLANK_CYC : LAT_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_t              state, state_n;
  logic [ROW_BITS-1:0] row_sh, a_q;
  logic                lat_q, oe_n_q, fd_q, lit;
  logic [ON_W-1:0]     on_cnt, on_cnt_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                start, sh_done, on_met;
  logic                blank_last, lat_last;

  hub75_bit_shifter #(
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .CLK_DIV  (CLK_DIV),
    .COL_BITS (COL_BITS)
  ) u_shifter (
    .clk      (clkin),
    .rst      (rstin),
    .start    (start),
    .row_sh   (row_sh),
    .pix_data (bus.pix_data),
    .pix_addr (bus.pix_addr),
    .pix_rd   (bus.pix_rd),
    .r1       (bus.R1),
    .sclk     (bus.clk),
    .done     (sh_done)
  );

  // on_met includes the current lit cycle, so the row leaves WAIT (or skips
  // it entirely) exactly when ON_CYC lit cycles have elapsed.
  assign on_cnt_nxt = (!oe_n_q && (on_cnt < ON_W'(ON_CYC))) ? on_cnt + ON_W'(1) : on_cnt;
  assign on_met     = (on_cnt_nxt >= ON_W'(ON_CYC));
  assign blank_last = (cnt == CNT_W'(BLANK_CYC - 1));
  assign lat_last   = (cnt == CNT_W'(LAT_CYC - 1));

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (sh_done)
          state_n = (lit && !on_met) ? WAIT : BLANK;
      end
      WAIT: begin
        if (on_met)
          state_n = BLANK;
      end
      BLANK: begin
        if (blank_last)
          state_n = LATCH;
      end
      LATCH: begin
        if (lat_last) begin
          if (en) begin
            state_n = SHIFT;
            start   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rstin) begin
      state  <= IDLE;
      row_sh <= '0;
      a_q    <= '0;
      lat_q  <= 1'b0;
      oe_n_q <= 1'b1;
      fd_q   <= 1'b0;
      lit    <= 1'b0;
      on_cnt <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      fd_q   <= 1'b0;
      on_cnt <= on_cnt_nxt;
      // cnt restarts on every state change; only BLANK/LATCH read it
      cnt    <= (state_n != state) ? '0 : cnt + CNT_W'(1);
      lat_q  <= (state_n == LATCH);
      if (state_n == BLANK)
        oe_n_q <= 1'b1;
      if (state == BLANK && cnt == '0)
        a_q <= row_sh;
      if (state == LATCH && lat_last) begin
        row_sh <= row_sh + ROW_BITS'(1);
        fd_q   <= &row_sh;
        lit    <= en;
        if (en) begin
          oe_n_q <= 1'b0;
          on_cnt <= '0;
        end
      end
    end
  end

  assign bus.A          = a_q;
  assign bus.lat        = lat_q;
  assign bus.oe_n       = oe_n_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
module tb_hub75_scan_ctrl;

  localparam int COLS      = 4;
  localparam int ROW_BITS  = 2;
  localparam int CLK_DIV   = 2;
  localparam int BLANK_CYC = 2;
  localparam int LAT_CYC   = 1;
  localparam int ON_CYC    = 20;
  localparam int NROWS     = 1 << ROW_BITS;
  localparam int BITP      = 2 * CLK_DIV;
  localparam int S         = COLS * BITP;

  logic clkin = 1'b0;
  logic rstin = 1'b1;
  logic en    = 1'b0;

  hub75_scan_ctrl_if #(.ROW_BITS(ROW_BITS), .COL_BITS($clog2(COLS))) bus();

  hub75_scan_ctrl #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .CLK_DIV(CLK_DIV),
    .BLANK_CYC(BLANK_CYC), .LAT_CYC(LAT_CYC), .ON_CYC(ON_CYC)
  ) dut (
    .clkin (clkin),
    .rstin (rstin),
    .en    (en),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  // frame memory: data one cycle after the strobe, noise otherwise
  logic mem [NROWS*COLS];
  always @(posedge clkin)
    bus.pix_data <= bus.pix_rd ? mem[bus.pix_addr] : 1'($urandom);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at t=%0t", nm, $time);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // Reference model: position within the current row period as a plain offset.
  bit m_go = 0, m_idle = 1, m_lit = 0, m_r1 = 0, m_fd = 0;
  int m_t = 0, m_row = 0, m_a = 0;

  function automatic int lit_end();
    return m_lit ? ((S > ON_CYC) ? S : ON_CYC) : S;
  endfunction

  always @(posedge clkin) begin
    int e;
    e = lit_end();
    if (rstin) begin
      m_go = 1; m_idle = 1; m_lit = 0; m_r1 = 0; m_fd = 0;
      m_t = 0; m_row = 0; m_a = 0;
    end else if (m_idle) begin
      m_fd = 0;
      if (en) begin
        m_idle = 0;
        m_t = 0;
      end
    end else begin
      m_fd = 0;
      if (m_t < S && (m_t % BITP) == 1)
        m_r1 = mem[m_row*COLS + m_t/BITP];
      if (m_t == e)
        m_a = m_row;
      if (m_t == e + BLANK_CYC + LAT_CYC - 1) begin
        m_fd   = (m_row == NROWS - 1);
        m_row  = (m_row + 1) % NROWS;
        m_lit  = en;
        m_idle = !en;
        m_t    = 0;
      end else begin
        m_t++;
      end
    end
  end

  // event log for the literal checks
  int q_rise[$], q_rise_r1[$], q_rd[$], q_lat[$], q_latA[$], q_latw[$], q_low[$], q_fd[$];
  int cyc = 0, first_low = -1, low_after_lat = 0, lat_len = 0, low_len = 0;
  logic p_clk = 0, p_lat = 0, p_oe = 1;

  always @(negedge clkin) begin
    if (m_go) begin
      int e;
      bit run, e_rd;
      e    = lit_end();
      run  = !m_idle;
      e_rd = run && m_t < S && (m_t % BITP) == 0;
      chk("oe_n", bus.oe_n, m_idle ? 1 : !(m_lit && m_t < e));
      chk("lat", bus.lat, run && m_t >= e + BLANK_CYC && m_t < e + BLANK_CYC + LAT_CYC);
      chk("clk", bus.clk, run && m_t < S && (m_t % BITP) >= CLK_DIV);
      chk("pix_rd", bus.pix_rd, e_rd);
      if (e_rd)
        chk("pix_addr", bus.pix_addr, m_row*COLS + m_t/BITP);
      chk("A", bus.A, m_a);
      chk("R1", bus.R1, m_r1);
      chk("frame_done", bus.frame_done, m_fd);

      cyc++;
      if (bus.clk === 1'b1 && p_clk !== 1'b1) begin
        q_rise.push_back(cyc);
        q_rise_r1.push_back(int'(bus.R1));
      end
      if (bus.pix_rd === 1'b1)
        q_rd.push_back(int'(bus.pix_addr));
      if (bus.lat === 1'b1) begin
        if (p_lat !== 1'b1) begin
          q_lat.push_back(cyc);
          q_latA.push_back(int'(bus.A));
          low_after_lat = 0;
        end
        lat_len++;
      end else if (p_lat === 1'b1) begin
        q_latw.push_back(lat_len);
        lat_len = 0;
      end
      if (bus.oe_n === 1'b0) begin
        low_len++;
        low_after_lat++;
        if (first_low < 0) first_low = cyc;
      end else if (p_oe === 1'b0) begin
        q_low.push_back(low_len);
        low_len = 0;
      end
      if (bus.frame_done === 1'b1)
        q_fd.push_back(cyc);
      p_clk = bus.clk;
      p_lat = bus.lat;
      p_oe  = bus.oe_n;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic clear_log();
    q_rise.delete(); q_rise_r1.delete(); q_rd.delete(); q_lat.delete();
    q_latA.delete(); q_latw.delete(); q_low.delete(); q_fd.delete();
    first_low = -1;
    low_after_lat = 0;
  endtask

  int row0_bits[4] = '{1, 0, 1, 1};

  initial begin
    int k;
    for (int i = 0; i < NROWS*COLS; i++) mem[i] = 1'($urandom);
    for (int i = 0; i < COLS; i++) mem[i] = row0_bits[i][0];

    // reset state
    step(3);
    chk("rst_oe_n", bus.oe_n, 1);
    chk("rst_lat", bus.lat, 0);
    chk("rst_clk", bus.clk, 0);
    chk("rst_A", bus.A, 0);
    chk("rst_pix_addr", bus.pix_addr, 0);
    chk("rst_pix_rd", bus.pix_rd, 0);
    chk("rst_R1", bus.R1, 0);
    chk("rst_frame_done", bus.frame_done, 0);

    // first frame
    rstin = 0;
    clear_log();
    en = 1;
    step(125);
    for (int i = 0; i < 4; i++) chk("row0_R1_at_rise", at(q_rise_r1, i), row0_bits[i]);
    for (int i = 0; i < 3; i++) chk("clk_rise_gap", at(q_rise, i+1) - at(q_rise, i), 4);
    for (int i = 0; i < 8; i++) chk("rd_addr_seq", at(q_rd, i), i);
    chk("lat0_after_rise0", at(q_lat, 0) - at(q_rise, 0), 16);
    chk("first_oe_low", first_low, at(q_lat, 0) + 1);
    for (int i = 0; i < 5; i++) chk("A_at_lat", at(q_latA, i), i % 4);
    for (int i = 0; i < 5; i++) chk("lat_width", at(q_latw, i), 1);
    for (int i = 0; i < 4; i++) chk("row_period", at(q_lat, i+1) - at(q_lat, i), 23);
    for (int i = 0; i < 4; i++) chk("oe_low_len", at(q_low, i), 20);
    chk("fd_count", q_fd.size(), 1);
    chk("fd_after_row3_lat", at(q_fd, 0), at(q_lat, 3) + 1);

    // drop en while row 2 is shifting
    k = 0;
    while (!(bus.pix_rd === 1'b1 && bus.pix_addr === 4'd9) && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) timeout("wait_row2_shift");
    en = 0;
    clear_log();
    step(80);
    chk("drop_lat_count", q_lat.size(), 1);
    chk("drop_lat_A", at(q_latA, 0), 2);
    chk("idle_dark", low_after_lat, 0);

    // re-enable resumes at row 3, dark until its latch
    clear_log();
    en = 1;
    step(30);
    chk("reen_first_addr", at(q_rd, 0), 12);
    chk("reen_last_addr", at(q_rd, 3), 15);
    chk("reen_A", at(q_latA, 0), 3);
    chk("reen_dark_until_lat", first_low, at(q_lat, 0) + 1);

    // random enable traffic
    for (int r = 0; r < 12; r++) begin
      en = 1'($urandom_range(0, 1));
      step($urandom_range(5, 60));
    end

    // reset during LATCH
    en = 1;
    k = 0;
    while (bus.lat !== 1'b1 && k < 200) begin
      step(1);
      k++;
    end
    if (k >= 200) timeout("wait_latch");
    rstin = 1;
    en = 0;
    step(1);
    chk("latrst_lat", bus.lat, 0);
    chk("latrst_oe_n", bus.oe_n, 1);
    chk("latrst_A", bus.A, 0);
    chk("latrst_clk", bus.clk, 0);
    chk("latrst_pix_rd", bus.pix_rd, 0);
    chk("latrst_frame_done", bus.frame_done, 0);
    rstin = 0;
    clear_log();
    step(10);
    chk("post_rst_no_reads", q_rd.size(), 0);
    chk("post_rst_dark", first_low, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
